// File: rtl/shift_chain_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// shift_ctrl_pkg
// Shared definitions for the shift_chain_ctrl serial shift sequencer.
//   state_t  : FSM encoding (IDLE / SHIFT / DONE)
//   calc_nb  : number of bit-periods per transfer for a given data width
// Optional feature macro: SHIFT_CHAIN_PARITY_EN (adds one parity bit period).
// ---------------------------------------------------------------------------
package shift_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   // Bit-periods per transfer: the data bits, plus the trailing parity bit
   // when parity is built in.
   function automatic int calc_nb(input int width);
`ifdef SHIFT_CHAIN_PARITY_EN
      return width + 1;
`else
      return width;
`endif
   endfunction

endpackage

// File: rtl/shift_chain_ctrl_dff_r.sv
// ---------------------------------------------------------------------------
// dff_r
// Single-bit D flip-flop with asynchronous active-high reset and load enable.
// One instance per bit forms the shift chain in shift_chain_ctrl.
//   i_clk : clock
//   i_rst : asynchronous active-high reset (clears the bit)
//   i_en  : load enable
//   i_d   : data in
//   o_q   : registered data out
// ---------------------------------------------------------------------------
module dff_r (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_d,
   output logic o_q
);

   logic r_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_q <= 1'b0;
      end else if (i_en) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/shift_chain_ctrl.sv
// ---------------------------------------------------------------------------
// shift_chain_ctrl
// Sequencer for a chain of flops used as a serial shift register. On start it
// captures a parallel word, shifts it out LSB first (one bit per CLK_DIV
// cycles) while shifting sin into the top of the same chain, then presents
// the received word with a one-cycle done pulse.
//
// Parameters:
//   WIDTH   : data bits per transfer (>= 2)
//   CLK_DIV : clock cycles per shifted bit (>= 1)
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   start      in   transfer request, sampled only in IDLE
//   din        in   parallel word captured when start is accepted
//   sin        in   serial input bit
//   ready      out  high in IDLE
//   busy       out  high in SHIFT and DONE
//   sout       out  serial output bit, LSB first
//   sout_valid out  high while a bit is driven on sout
//   done       out  one-cycle completion pulse
//   dout       out  received word, held until the next done
//   par_err    out  parity mismatch flag, valid with done
// Optional feature macro: SHIFT_CHAIN_PARITY_EN
//   When defined, an even-parity bit of din follows the data bits, and the
//   matching received bit is checked against the received data.
// ---------------------------------------------------------------------------
module shift_chain_ctrl
   import shift_ctrl_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int CLK_DIV = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] din,
   input  logic             sin,
   output logic             ready,
   output logic             busy,
   output logic             sout,
   output logic             sout_valid,
   output logic             done,
   output logic [WIDTH-1:0] dout,
   output logic             par_err
);

   localparam int NB    = calc_nb(WIDTH);
   localparam int BIT_W = $clog2(NB + 1);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NB - 1);

   state_t             r_state;
   logic [DIV_W-1:0]   r_div;
   logic [BIT_W-1:0]   r_bit_cnt;
   logic               r_ready;
   logic               r_busy;
   logic               r_sout_valid;
   logic               r_done;
   logic [WIDTH-1:0]   r_dout;

   logic [WIDTH-1:0]   w_chain;
   logic [WIDTH-1:0]   w_chain_nxt;
   logic               w_chain_en;
   logic               w_load;
   logic               w_bit_end;
   logic               w_last_bit;
   logic               w_shift_en;

   assign w_load     = (r_state == IDLE) && start;
   assign w_bit_end  = (r_state == SHIFT) && (r_div == DIV_LAST);
   assign w_last_bit = (r_bit_cnt == BIT_LAST);

`ifdef SHIFT_CHAIN_PARITY_EN
   logic r_par_tx;
   logic r_par_err;
   logic w_par_phase;

   // The trailing parity period does not move the chain, so the chain still
   // holds exactly the received data word when DONE is entered.
   assign w_par_phase = (r_bit_cnt == BIT_W'(WIDTH));
   assign w_shift_en  = w_bit_end && !w_par_phase;
   assign sout        = r_sout_valid && (w_par_phase ? r_par_tx : w_chain[0]);
   assign par_err     = r_par_err;
`else
   assign w_shift_en  = w_bit_end;
   assign sout        = r_sout_valid && w_chain[0];
   assign par_err     = 1'b0;
`endif

   // Next chain value: parallel load on accept, right shift with sin entering
   // at the top on each bit boundary, otherwise hold.
   assign w_chain_nxt = w_load     ? din :
                        w_shift_en ? {sin, w_chain[WIDTH-1:1]} :
                                     w_chain;
   assign w_chain_en  = w_load || w_shift_en;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_chain
         dff_r u_bit (
            .i_clk (clk),
            .i_rst (rst),
            .i_en  (w_chain_en),
            .i_d   (w_chain_nxt[gi]),
            .o_q   (w_chain[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_div        <= '0;
         r_bit_cnt    <= '0;
         r_ready      <= 1'b1;
         r_busy       <= 1'b0;
         r_sout_valid <= 1'b0;
         r_done       <= 1'b0;
         r_dout       <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state      <= SHIFT;
                  r_div        <= '0;
                  r_bit_cnt    <= '0;
                  r_ready      <= 1'b0;
                  r_busy       <= 1'b1;
                  r_sout_valid <= 1'b1;
               end
            end
            SHIFT: begin
               if (w_bit_end) begin
                  r_div     <= '0;
                  r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                  if (w_last_bit) begin
                     r_state      <= DONE;
                     r_sout_valid <= 1'b0;
                     r_done       <= 1'b1;
                     // Capture the word as it will stand after this edge.
                     r_dout       <= w_chain_nxt;
                  end
               end else begin
                  r_div <= r_div + DIV_W'(1);
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_ready <= 1'b1;
            end
            default: begin
               r_state      <= IDLE;
               r_done       <= 1'b0;
               r_busy       <= 1'b0;
               r_ready      <= 1'b1;
               r_sout_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef SHIFT_CHAIN_PARITY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_par_tx  <= 1'b0;
         r_par_err <= 1'b0;
      end else begin
         if (w_load) begin
            r_par_tx <= ^din;
         end
         // Final period is the parity bit: compare it with the received data.
         if (w_bit_end && w_last_bit) begin
            r_par_err <= sin ^ (^w_chain);
         end
      end
   end
`endif

   assign ready      = r_ready;
   assign busy       = r_busy;
   assign sout_valid = r_sout_valid;
   assign done       = r_done;
   assign dout       = r_dout;

endmodule

// File: tb/tb_shift_chain_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shift_chain_ctrl
// Self-checking bench for shift_chain_ctrl. Two instances: CLK_DIV=1 (table
// of transfers, reset, start-while-busy, reset mid-transfer) and CLK_DIV=3
// (divided bit timing). Expected done results travel through per-instance
// scoreboard queues and are compared when done is seen.
// ---------------------------------------------------------------------------
module tb_shift_chain_ctrl;

   localparam int W = 8;
`ifdef SHIFT_CHAIN_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int NB = W + PAR;

   typedef struct {
      logic [7:0] din;
      bit         loop;
      bit         sinv;
      bit         force_par0;
      bit         busy_pulse;
      logic [7:0] exp_dout;
   } vec_t;

   typedef struct {
      logic [7:0] dout;
      logic       perr;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       start1 = 1'b0, loop1 = 1'b0, sin_val1 = 1'b0;
   logic [7:0] din1 = '0;
   logic       sin1, ready1, busy1, sout1, sv1, done1, perr1;
   logic [7:0] dout1;

   logic       start3 = 1'b0, sin3 = 1'b0;
   logic [7:0] din3 = '0;
   logic       ready3, busy3, sout3, sv3, done3, perr3;
   logic [7:0] dout3;

   exp_t q1[$];
   exp_t q3[$];
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   assign sin1 = loop1 ? sout1 : sin_val1;

   shift_chain_ctrl #(.WIDTH(W), .CLK_DIV(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .din(din1), .sin(sin1),
      .ready(ready1), .busy(busy1), .sout(sout1), .sout_valid(sv1),
      .done(done1), .dout(dout1), .par_err(perr1)
   );

   shift_chain_ctrl #(.WIDTH(W), .CLK_DIV(3)) u_dut3 (
      .clk(clk), .rst(rst), .start(start3), .din(din3), .sin(sin3),
      .ready(ready3), .busy(busy3), .sout(sout3), .sout_valid(sv3),
      .done(done3), .dout(dout3), .par_err(perr3)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic model_perr(input logic [7:0] rx_data, input logic rx_par);
      return (PAR != 0) ? (rx_par ^ (^rx_data)) : 1'b0;
   endfunction

   // Scoreboard monitors: every done pulse must match a queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (done1) begin
         if (q1.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL dut1_spurious_done: got done=1 expected no done at %0t", $time);
         end else begin
            e = q1.pop_front();
            check("dut1_dout", dout1, e.dout);
            check("dut1_par_err", perr1, e.perr);
            $display("xfer dut1: dout=%h par_err=%b (exp %h/%b)", dout1, perr1, e.dout, e.perr);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (done3) begin
         if (q3.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL dut3_spurious_done: got done=1 expected no done at %0t", $time);
         end else begin
            e = q3.pop_front();
            check("dut3_dout", dout3, e.dout);
            check("dut3_par_err", perr3, e.perr);
            $display("xfer dut3: dout=%h par_err=%b (exp %h/%b)", dout3, perr3, e.dout, e.perr);
         end
      end
   end

   // One CLK_DIV=1 transfer; called in the cycle start is to be raised.
   // Returns at the negedge of the cycle after done, so a following call
   // raises start in the earliest legal cycle.
   task automatic xfer1(input vec_t v);
      logic [8:0] bits;
      logic       rx_par;
      exp_t       e;
      bits   = {^v.din, v.din};
      rx_par = v.force_par0 ? 1'b0 : (v.loop ? ^v.din : v.sinv);
      e.dout = v.exp_dout;
      e.perr = model_perr(v.exp_dout, rx_par);
      q1.push_back(e);
      din1     = v.din;
      loop1    = v.loop;
      sin_val1 = v.sinv;
      start1   = 1'b1;
      for (int c = 1; c <= NB + 1; c++) begin
         @(posedge clk);
         #1;
         start1 = v.busy_pulse && (c == 4);
         if (start1) din1 = 8'h00;
         if (PAR != 0 && v.force_par0 && c == NB) begin
            loop1    = 1'b0;
            sin_val1 = 1'b0;
         end
         @(negedge clk);
         if (c <= NB) begin
            check($sformatf("dut1_sout_b%0d", c - 1), sout1, bits[c-1]);
            check("dut1_sout_valid", sv1, 1'b1);
            check("dut1_busy", busy1, 1'b1);
            check("dut1_done_early", done1, 1'b0);
         end else begin
            check("dut1_done_cycle", done1, 1'b1);
            check("dut1_busy_in_done", busy1, 1'b1);
            check("dut1_sout_valid_done", sv1, 1'b0);
         end
      end
      @(posedge clk);
      #1;
      loop1    = v.loop;
      sin_val1 = v.sinv;
      @(negedge clk);
      check("dut1_ready_after", ready1, 1'b1);
      check("dut1_busy_after", busy1, 1'b0);
      check("dut1_done_width", done1, 1'b0);
      check("dut1_dout_hold", dout1, v.exp_dout);
      check("dut1_par_err_hold", perr1, e.perr);
   endtask

   vec_t vecs[8];

   initial begin
      exp_t e3;
      logic [7:0] bits3;

      vecs[0] = '{din: 8'hA5, loop: 1, sinv: 0, force_par0: 0, busy_pulse: 0, exp_dout: 8'hA5};
      vecs[1] = '{din: 8'h3C, loop: 0, sinv: 1, force_par0: 0, busy_pulse: 0, exp_dout: 8'hFF};
      vecs[2] = '{din: 8'h5A, loop: 0, sinv: 0, force_par0: 0, busy_pulse: 0, exp_dout: 8'h00};
      vecs[3] = '{din: 8'hA5, loop: 1, sinv: 0, force_par0: 0, busy_pulse: 1, exp_dout: 8'hA5};
      vecs[4] = '{din: 8'h07, loop: 1, sinv: 0, force_par0: 0, busy_pulse: 0, exp_dout: 8'h07};
      vecs[5] = '{din: 8'h07, loop: 1, sinv: 0, force_par0: 1, busy_pulse: 0, exp_dout: 8'h07};
      vecs[6] = '{din: 8'hFF, loop: 1, sinv: 0, force_par0: 0, busy_pulse: 0, exp_dout: 8'hFF};
      vecs[7] = '{din: 8'h81, loop: 0, sinv: 1, force_par0: 0, busy_pulse: 0, exp_dout: 8'hFF};

      // Reset held for 3 cycles with start requested on both instances.
      start1 = 1'b1;
      start3 = 1'b1;
      din1   = 8'hFF;
      din3   = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_ready", ready1, 1'b1);
         check("rst_busy", busy1, 1'b0);
         check("rst_sout", sout1, 1'b0);
         check("rst_sout_valid", sv1, 1'b0);
         check("rst_done", done1, 1'b0);
         check("rst_dout", dout1, 8'h00);
         check("rst_par_err", perr1, 1'b0);
         check("rst_ready3", ready3, 1'b1);
         check("rst_busy3", busy3, 1'b0);
      end
      @(posedge clk);
      #1;
      rst    = 1'b0;
      start1 = 1'b0;
      start3 = 1'b0;
      @(negedge clk);
      check("post_rst_idle", ready1, 1'b1);
      check("post_rst_busy", busy1, 1'b0);

      // Table-driven CLK_DIV=1 transfers, issued back to back.
      @(posedge clk);
      #1;
      foreach (vecs[i]) xfer1(vecs[i]);

      // Divided clock: each bit held 3 cycles, done at T+1+3*NB.
      bits3 = 8'h3C;
      e3.dout = 8'hFF;
      e3.perr = model_perr(8'hFF, 1'b1);
      q3.push_back(e3);
      din3   = 8'h3C;
      sin3   = 1'b1;
      start3 = 1'b1;
      for (int c = 1; c <= NB * 3 + 1; c++) begin
         @(posedge clk);
         #1;
         start3 = 1'b0;
         din3   = 8'h00;
         @(negedge clk);
         if (c <= NB * 3) begin
            if ((c - 1) / 3 < W) begin
               check($sformatf("dut3_sout_c%0d", c), sout3, bits3[(c-1)/3]);
            end else begin
               check("dut3_sout_parity", sout3, ^bits3);
            end
            check("dut3_sout_valid", sv3, 1'b1);
            check("dut3_done_early", done3, 1'b0);
         end else begin
            check("dut3_done_cycle", done3, 1'b1);
         end
      end
      @(negedge clk);
      check("dut3_ready_after", ready3, 1'b1);
      check("dut3_dout_hold", dout3, 8'hFF);

      // Reset mid-transfer: raised in cycle T+5, aborts immediately.
      @(posedge clk);
      #1;
      din1   = 8'hA5;
      loop1  = 1'b1;
      start1 = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk);
         #1;
         start1 = 1'b0;
         if (c == 5) rst = 1'b1;
         @(negedge clk);
         if (c < 5) check("abort_busy_before", busy1, 1'b1);
      end
      check("abort_ready_in_rst", ready1, 1'b1);
      check("abort_busy_in_rst", busy1, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_ready", ready1, 1'b1);
      check("abort_busy", busy1, 1'b0);
      check("abort_dout", dout1, 8'h00);
      check("abort_done", done1, 1'b0);
      check("abort_sout_valid", sv1, 1'b0);

      // A new transfer after the abort completes normally.
      xfer1(vecs[0]);

      // Idle stretch: no further done pulses or restarts.
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("idle_busy", busy1, 1'b0);
      end
      check("sb1_empty", q1.size(), 0);
      check("sb3_empty", q3.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

endmodule
